sensor_acq_sequencer: RTL and testbench

- Sequences sensor acquisitions for one control period, starting on each timing-manager `trigger` pulse.
- Launches every enabled sensor with a one-cycle start pulse, staggered by a programmable gap to limit simultaneous switching.
- Tracks done rising edges and runs a watchdog, then reports completion and per-sensor timeouts.
- Sits between the timing manager (`trigger`, `en_bits`) and the eddy/encoder/ADC interface blocks.

---
 rtl/sensor_acq_sequencer_pkg.sv | 32 +++
 rtl/sensor_acq_sequencer_if.sv | 50 +++++
 rtl/sensor_acq_sequencer_picker.sv | 21 ++
 rtl/sensor_acq_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_sensor_acq_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_acq_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_acq_pkg
//  Purpose  : Shared types and constants for the sensor acquisition sequencer:
//             FSM state encoding, sensor bit positions and default sizes.
//  Ports    : none (package)
//  Config   : SEQ_RETRY_EN (used by sensor_acq_sequencer, not here)
//  Revision : 1.0  initial release
// ============================================================================
package sensor_acq_pkg;

  localparam int DEF_N_SENSORS = 6;
  localparam int DEF_TIME_W    = 16;

  // Bit positions within en_bits / done_in / start_out.
  localparam int SENS_EDDY0   = 0;
  localparam int SENS_EDDY1   = 1;
  localparam int SENS_EDDY2   = 2;
  localparam int SENS_EDDY3   = 3;
  localparam int SENS_ENCODER = 4;
  localparam int SENS_ADC     = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    GAP    = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/sensor_acq_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_acq_sequencer_if
//  Purpose  : Bundles the timing-manager controls, sensor start/done lines and
//             status outputs of the sensor acquisition sequencer.
//  Modports : slave  - the sequencer (consumes controls, drives status)
//             master - the timing manager / sensor side
//  Config   : SEQ_RETRY_EN adds retry_count (8 bits)
//  Revision : 1.0  initial release
// ============================================================================
interface sensor_acq_sequencer_if
  import sensor_acq_pkg::*;
#(
  parameter int N_SENSORS = DEF_N_SENSORS,
  parameter int TIME_W    = DEF_TIME_W
);

  logic                 trigger;
  logic [N_SENSORS-1:0] en_bits;
  logic [TIME_W-1:0]    launch_gap;
  logic [TIME_W-1:0]    timeout;
  logic [N_SENSORS-1:0] done_in;
  logic                 clear_flags;
  logic [N_SENSORS-1:0] start_out;
  logic                 busy;
  logic                 cycle_done;
  logic [N_SENSORS-1:0] timeout_flags;
  logic                 overrun;
`ifdef SEQ_RETRY_EN
  logic [7:0]           retry_count;
`endif

  modport slave (
    input  trigger, en_bits, launch_gap, timeout, done_in, clear_flags,
`ifdef SEQ_RETRY_EN
    output retry_count,
`endif
    output start_out, busy, cycle_done, timeout_flags, overrun
  );

  modport master (
    output trigger, en_bits, launch_gap, timeout, done_in, clear_flags,
`ifdef SEQ_RETRY_EN
    input  retry_count,
`endif
    input  start_out, busy, cycle_done, timeout_flags, overrun
  );

endinterface
`default_nettype wire

// File: rtl/sensor_acq_sequencer_picker.sv
`default_nettype none
// ============================================================================
//  Module   : seq_lsb_picker
//  Purpose  : Combinational lowest-set-bit picker; returns a one-hot vector
//             with only the least significant set bit of vec (zero if none).
//  Ports    : vec    in  WIDTH  candidate mask
//             onehot out WIDTH  lowest set bit of vec
//  Revision : 1.0  initial release
// ============================================================================
module seq_lsb_picker #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] onehot
);

  // Two's complement isolates the lowest set bit.
  assign onehot = vec & (~vec + {{(WIDTH-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/sensor_acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_acq_sequencer
//  Purpose  : Per-period sensor acquisition sequencer. On trigger, issues a
//             one-cycle start pulse to each enabled sensor (lowest index
//             first, launch_gap idle cycles apart), collects done edges,
//             runs a watchdog and reports completion / per-sensor timeouts.
//  Ports    : clk, rst_n (async, active low)
//             bus (sensor_acq_sequencer_if.slave):
//               trigger, en_bits, launch_gap, timeout, done_in, clear_flags
//               start_out, busy, cycle_done, timeout_flags, overrun
//               retry_count (only with SEQ_RETRY_EN)
//  Config   : SEQ_RETRY_EN - one relaunch of unfinished sensors on the first
//             watchdog expiry before flags are raised.
//  Revision : 1.0  initial release
// ============================================================================
module sensor_acq_sequencer
  import sensor_acq_pkg::*;
#(
  parameter int N_SENSORS = DEF_N_SENSORS,
  parameter int TIME_W    = DEF_TIME_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sensor_acq_sequencer_if.slave bus
);

  localparam logic [TIME_W-1:0] WD_MAX = '1;
  localparam logic [TIME_W-1:0] ONE_T  = {{(TIME_W-1){1'b0}}, 1'b1};

  seq_state_e state;

  logic [N_SENSORS-1:0] done_q;
  logic [N_SENSORS-1:0] en_lat;
  logic [N_SENSORS-1:0] pending;
  logic [N_SENSORS-1:0] seen;
  logic [TIME_W-1:0]    gap_cnt;
  logic [TIME_W-1:0]    wd;

  logic [N_SENSORS-1:0] start_r;
  logic [N_SENSORS-1:0] flags_r;
  logic                 busy_r;
  logic                 cycle_done_r;
  logic                 overrun_r;

  logic [N_SENSORS-1:0] done_pe;
  logic [N_SENSORS-1:0] issued;
  logic [N_SENSORS-1:0] unseen;
  logic [N_SENSORS-1:0] pick_src;
  logic [N_SENSORS-1:0] pick;
  logic                 wd_expired;
  logic                 do_retry;
  logic                 accept;

  assign done_pe    = bus.done_in & ~done_q;
  // A sensor counts as issued once its pulse cycle is over: it is no longer
  // pending and not being pulsed right now.
  assign issued     = en_lat & ~pending & ~start_r;
  assign unseen     = en_lat & ~seen;
  assign wd_expired = (bus.timeout != '0) && (wd >= bus.timeout);
  assign accept     = (state == IDLE) && bus.trigger && (bus.en_bits != '0);

  // One picker serves all launch points: the first launch out of IDLE, the
  // following launches from pending, and a retry reload from WAIT.
  always_comb begin
    pick_src = pending;
    case (state)
      IDLE:    pick_src = bus.en_bits;
      WAIT:    pick_src = unseen;
      default: pick_src = pending;
    endcase
  end

  seq_lsb_picker #(.WIDTH(N_SENSORS)) u_picker (
    .vec    (pick_src),
    .onehot (pick)
  );

`ifdef SEQ_RETRY_EN
  logic       retried;
  logic [7:0] retry_cnt;
  logic       retry_take;

  assign do_retry   = ~retried;
  assign retry_take = (state == WAIT) && (seen != en_lat) && wd_expired && ~retried;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retried   <= 1'b0;
      retry_cnt <= 8'd0;
    end else begin
      if (accept) begin
        retried <= 1'b0;
      end else if (retry_take) begin
        retried <= 1'b1;
      end
      // A retry in the same cycle as clear_flags still counts.
      if (retry_take) begin
        retry_cnt <= (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
      end else if (bus.clear_flags) begin
        retry_cnt <= 8'd0;
      end
    end
  end

  assign bus.retry_count = retry_cnt;
`else
  assign do_retry = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      done_q       <= '0;
      en_lat       <= '0;
      pending      <= '0;
      seen         <= '0;
      gap_cnt      <= '0;
      wd           <= '0;
      start_r      <= '0;
      flags_r      <= '0;
      busy_r       <= 1'b0;
      cycle_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      done_q       <= bus.done_in;
      start_r      <= '0;
      cycle_done_r <= 1'b0;

      // Sticky status: a new set in the same cycle as clear_flags wins.
      overrun_r <= (overrun_r & ~bus.clear_flags) | (bus.trigger & (state != IDLE));
      if (bus.clear_flags) begin
        flags_r <= '0;
      end

      if ((state == LAUNCH) || (state == GAP) || (state == WAIT)) begin
        seen <= seen | (done_pe & issued);
        wd   <= (wd == WD_MAX) ? wd : wd + ONE_T;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            en_lat  <= bus.en_bits;
            pending <= bus.en_bits & ~pick;
            start_r <= pick;
            seen    <= '0;
            wd      <= '0;
            busy_r  <= 1'b1;
            state   <= LAUNCH;
          end
        end

        LAUNCH: begin
          if (pending != '0) begin
            if (bus.launch_gap != '0) begin
              gap_cnt <= bus.launch_gap;
              state   <= GAP;
            end else begin
              start_r <= pick;
              pending <= pending & ~pick;
            end
          end else begin
            state <= WAIT;
          end
        end

        GAP: begin
          if (gap_cnt <= ONE_T) begin
            start_r <= pick;
            pending <= pending & ~pick;
            state   <= LAUNCH;
          end else begin
            gap_cnt <= gap_cnt - ONE_T;
          end
        end

        WAIT: begin
          // Completion is judged before the watchdog so it wins a tie.
          if (seen == en_lat) begin
            cycle_done_r <= 1'b1;
            state        <= DONE;
          end else if (wd_expired) begin
            if (do_retry) begin
              pending <= unseen & ~pick;
              start_r <= pick;
              wd      <= '0;
              state   <= LAUNCH;
            end else begin
              flags_r      <= (bus.clear_flags ? '0 : flags_r) | unseen;
              cycle_done_r <= 1'b1;
              state        <= DONE;
            end
          end
        end

        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_out     = start_r;
  assign bus.busy          = busy_r;
  assign bus.cycle_done    = cycle_done_r;
  assign bus.timeout_flags = flags_r;
  assign bus.overrun       = overrun_r;

endmodule
`default_nettype wire

// File: tb/tb_sensor_acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sensor_acq_sequencer
//  Purpose  : Self-checking bench for sensor_acq_sequencer (default build).
//             Start pulses and cycle_done are checked by a negedge monitor
//             against an event queue filled when each trigger is driven.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sensor_acq_sequencer;

  localparam int NS = 6;
  localparam int TW = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  sensor_acq_sequencer_if #(.N_SENSORS(NS), .TIME_W(TW)) bus ();

  sensor_acq_sequencer #(.N_SENSORS(NS), .TIME_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [5:0] start;
    logic       done;
  } ev_t;

  typedef struct {
    logic [5:0] en;
    int         gap;
    int         to;
    int         d;          // cycle offset of done rising edge, 0 = never
    logic [5:0] flags;      // expected timeout_flags
    int         done_off;   // expected cycle_done offset from trigger cycle
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: every start pulse or cycle_done must match the next
  // expected event in time and value.
  always @(negedge clk) begin
    if (rst_n && (bus.start_out != '0 || bus.cycle_done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d start_out=%b cycle_done=%b, required no event",
                 cyc, bus.start_out, bus.cycle_done);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.start != bus.start_out || e.done != bus.cycle_done) begin
          errors++;
          $display("FAIL event: got cyc=%0d start_out=%b cycle_done=%b, required cyc=%0d start_out=%b cycle_done=%b",
                   cyc, bus.start_out, bus.cycle_done, e.cyc, e.start, e.done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Pushes the start pulses the enable mask should produce: lowest index
  // first, one pulse every gap+1 cycles starting the cycle after trigger.
  task automatic push_starts(input logic [5:0] en, input int gap, input int t);
    int s;
    s = t + 1;
    for (int i = 0; i < NS; i++) begin
      if (en[i]) begin
        exp_q.push_back('{cyc: s, start: 6'(1 << i), done: 1'b0});
        s += gap + 1;
      end
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   t;
    v = vecs[idx];
    bus.en_bits    = v.en;
    bus.launch_gap = TW'(v.gap);
    bus.timeout    = TW'(v.to);
    next_cycle();
    t = cyc;
    bus.trigger = 1'b1;
    push_starts(v.en, v.gap, t);
    exp_q.push_back('{cyc: t + v.done_off, start: 6'd0, done: 1'b1});
    next_cycle();
    bus.trigger = 1'b0;
    chk($sformatf("vec%0d_busy", idx), 32'(bus.busy), 32'd1);
    while (cyc < t + v.done_off + 1) begin
      if (v.d != 0 && cyc == t + v.d) bus.done_in = v.en;
      next_cycle();
    end
    chk($sformatf("vec%0d_flags", idx), 32'(bus.timeout_flags), 32'(v.flags));
    chk($sformatf("vec%0d_idle", idx), 32'(bus.busy), 32'd0);
    chk_queue_empty($sformatf("vec%0d_events", idx));
    bus.clear_flags = 1'b1;
    bus.done_in     = '0;
    next_cycle();
    bus.clear_flags = 1'b0;
    if (v.flags != '0) chk($sformatf("vec%0d_cleared", idx), 32'(bus.timeout_flags), 32'd0);
  endtask

  task automatic overrun_seq(input logic with_clear);
    int t;
    bus.en_bits    = 6'b000001;
    bus.launch_gap = '0;
    bus.timeout    = '0;
    next_cycle();
    t = cyc;
    bus.trigger = 1'b1;
    exp_q.push_back('{cyc: t + 1, start: 6'b000001, done: 1'b0});
    exp_q.push_back('{cyc: t + 10, start: 6'd0, done: 1'b1});
    next_cycle();
    bus.trigger = 1'b0;
    while (cyc < t + 11) begin
      if (cyc == t + 3) begin
        bus.trigger     = 1'b1;
        bus.en_bits     = 6'b111111;
        bus.clear_flags = with_clear;
      end
      if (cyc == t + 4) begin
        bus.trigger     = 1'b0;
        bus.clear_flags = 1'b0;
        chk(with_clear ? "overrun_set_beats_clear" : "overrun_set", 32'(bus.overrun), 32'd1);
      end
      if (cyc == t + 8) bus.done_in = 6'b000001;
      next_cycle();
    end
    chk_queue_empty("overrun_events");
    bus.done_in = '0;
  endtask

  initial begin
    int t;
    // en, gap, timeout, done offset, flags, cycle_done offset
    vecs[0] = '{6'b100001, 3, 100, 30, 6'b000000, 32};
    vecs[1] = '{6'b000111, 0,   0, 10, 6'b000000, 12};
    vecs[2] = '{6'b010000, 0,  10,  0, 6'b010000, 12};
    vecs[3] = '{6'b111111, 2,  50, 25, 6'b000000, 27};
    vecs[4] = '{6'b101010, 1,   8,  0, 6'b101010, 10};
    vecs[5] = '{6'b001100, 5,  20, 15, 6'b000000, 17};
    vecs[6] = '{6'b010000, 0,  10, 10, 6'b000000, 12};  // done edge lands on expiry

    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.trigger = 1'b0; bus.en_bits = '0; bus.launch_gap = '0;
    bus.timeout = '0; bus.done_in = '0; bus.clear_flags = 1'b0;
    repeat (3) next_cycle();
    chk("reset_start_out", 32'(bus.start_out), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_cycle_done", 32'(bus.cycle_done), 32'd0);
    chk("reset_flags", 32'(bus.timeout_flags), 32'd0);
    chk("reset_overrun", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 7; i++) run_vec(i);

    // Separate done edges for the two sensors.
    bus.en_bits = 6'b100001; bus.launch_gap = 16'd3; bus.timeout = 16'd100;
    next_cycle();
    t = cyc;
    bus.trigger = 1'b1;
    push_starts(6'b100001, 3, t);
    exp_q.push_back('{cyc: t + 32, start: 6'd0, done: 1'b1});
    next_cycle();
    bus.trigger = 1'b0;
    while (cyc < t + 33) begin
      if (cyc == t + 20) bus.done_in = 6'b000001;
      if (cyc == t + 30) bus.done_in = 6'b100001;
      if (cyc == t + 31) chk("split_done_busy", 32'(bus.busy), 32'd1);
      next_cycle();
    end
    chk("split_done_flags", 32'(bus.timeout_flags), 32'd0);
    chk_queue_empty("split_done_events");
    bus.done_in = '0;

    // Empty enable mask: trigger is ignored.
    bus.en_bits = '0;
    next_cycle();
    bus.trigger = 1'b1;
    next_cycle();
    bus.trigger = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("empty_en_busy", 32'(bus.busy), 32'd0);
      next_cycle();
    end

    // Overrun, then clear, then overrun with a simultaneous clear.
    overrun_seq(1'b0);
    bus.clear_flags = 1'b1;
    next_cycle();
    bus.clear_flags = 1'b0;
    chk("overrun_cleared", 32'(bus.overrun), 32'd0);
    overrun_seq(1'b1);
    chk("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Reset during GAP: everything drops at once.
    bus.en_bits = 6'b100001; bus.launch_gap = 16'd5; bus.timeout = '0;
    next_cycle();
    t = cyc;
    bus.trigger = 1'b1;
    exp_q.push_back('{cyc: t + 1, start: 6'b000001, done: 1'b0});
    next_cycle();
    next_cycle();
    chk("gap_busy", 32'(bus.busy), 32'd1);
    chk("gap_overrun_pre", 32'(bus.overrun), 32'd1);
    bus.trigger = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_gap_busy", 32'(bus.busy), 32'd0);
    chk("rst_gap_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_gap_start", 32'(bus.start_out), 32'd0);
    chk("rst_gap_cycle_done", 32'(bus.cycle_done), 32'd0);
    chk_queue_empty("rst_gap_events");
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Reset while a start pulse is high: the pulse drops immediately.
    bus.en_bits = 6'b000001; bus.launch_gap = '0;
    next_cycle();
    t = cyc;
    bus.trigger = 1'b1;
    next_cycle();
    bus.trigger = 1'b0;
    chk("pre_rst_start", 32'(bus.start_out), 32'h01);
    rst_n = 1'b0;
    #1;
    chk("rst_launch_start", 32'(bus.start_out), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Normal operation resumes after reset.
    run_vec(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
